lsu_dmem: RTL and testbench
===========================

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words (power of two, 4..4096).
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning the number of wait cycles inserted per access (0..7).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock, rising-edge.
REQ-004 The module SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 The module SHALL have port i_req  input  1  meaning the access request, sampled only when o_ready=1.
REQ-006 The module SHALL have port i_we  input  1  meaning 1=store, 0=load.
REQ-007 The module SHALL have port i_addr  input  32  meaning the byte address.
REQ-008 The module SHALL have port i_size  input  2  meaning 00=byte, 01=half, 10=word, 11=reserved (treated as word).
REQ-009 The module SHALL have port i_unsigned  input  1  meaning zero-extend load data when 1, sign-extend when 0.
REQ-010 The module SHALL have port i_wdata  input  32  meaning store data, with the byte or half taken from the low bits.
REQ-011 The module SHALL have port o_ready  output  1  meaning the unit can accept a request this cycle.
REQ-012 The module SHALL have port o_valid  output  1  meaning a one-cycle completion pulse.
REQ-013 The module SHALL have port o_rdata  output  32  meaning extended load data, valid with o_valid.
REQ-014 The module SHALL have port o_misalign  output  1  meaning the completed access was misaligned, valid with o_valid.

Function
REQ-015 Word index SHALL be i_addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored (address wrap-around modulo 4*DEPTH bytes).
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; o_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE with i_req=1, the unit SHALL latch we/addr/size/unsigned/wdata and go to WAIT, or go directly to RESP if LATENCY=0.
REQ-018 WAIT SHALL last exactly LATENCY cycles, tracked by a down-counter loaded at accept, then go to RESP.
REQ-019 RESP SHALL last one cycle with o_valid=1 and then return to IDLE; accept-to-o_valid latency SHALL be LATENCY+1 cycles, and back-to-back throughput SHALL be one access per LATENCY+2 cycles.
REQ-020 A store SHALL update memory on the clock edge leaving the last WAIT cycle (or the accept edge if LATENCY=0), writing only the addressed lanes: byte lane addr[1:0]; half lanes addr[1]*2 and addr[1]*2+1.
REQ-021 Load data SHALL be read from the latched address, lane-selected and zero- or sign-extended per the latched unsigned flag; word loads SHALL ignore the unsigned flag.
REQ-022 Misalignment SHALL be half with addr[0]=1, or word/reserved with addr[1:0]!=0; a misaligned access SHALL not write memory, SHALL complete with o_rdata=0 and o_misalign=1, and SHALL keep the normal latency.
REQ-023 i_req while o_ready=0 SHALL be ignored without being queued.
REQ-024 Outside RESP, o_valid, o_misalign and o_rdata SHALL be 0.

Reset
REQ-025 Asserting rst (low) SHALL immediately force IDLE, clear the counter, set o_ready=1 and o_valid=o_misalign=0 and o_rdata=0, and discard any pending access (an in-flight store SHALL not write).
REQ-026 Memory contents SHALL not be reset.

Configuration
REQ-027 With macro LSU_DMEM_PERF_EN defined, the module SHALL add output o_access_cnt (32 bits), which SHALL increment on every o_valid pulse, saturate at 0xFFFFFFFF, and reset to 0.
REQ-028 Without LSU_DMEM_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then store word 0xDEADBEEF at 0x10 and load word from 0x10 (LATENCY=2) -> o_valid 3 cycles after each accept, with load rdata=0xDEADBEEF and o_misalign=0.
REQ-030 Store byte 0x80 at 0x11 over the word 0x00000000, then load byte signed and unsigned at 0x11 -> 0xFFFFFF80 and 0x00000080 respectively, and a word load returns 0x00008000.
REQ-031 Store half at 0x13 -> o_misalign=1, rdata=0, and a subsequent word load at 0x10 is unchanged.
REQ-032 With DEPTH=64, store word 0x12345678 at 0x100, then load from 0x000 -> 0x12345678 (wrap-around).
REQ-033 Assert rst low during WAIT of a store to 0x20 holding 0xAAAAAAAA -> o_ready=1 immediately, no o_valid pulse, and a later load of 0x20 returns the prior value.
REQ-034 With LATENCY=0 and LSU_DMEM_PERF_EN defined, issue 5 back-to-back loads with i_req held high -> o_valid every 2 cycles and o_access_cnt=5.

Source files
------------

// File: rtl/lsu_dmem.sv
// lsu_dmem: word-organised data memory behind a load/store handshake
// Optional LSU_DMEM_PERF_EN adds a saturating completed-access counter
module lsu_dmem #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_misalign
`ifdef LSU_DMEM_PERF_EN
  ,
  output logic [31:0] o_access_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LOADCNT =
    (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t stateNext;
  logic [2:0] cnt;
  logic [2:0] cntNext;

  logic          reqWe;
  logic [AW+1:0] reqAddr;
  logic [1:0]    reqSize;
  logic          reqUns;
  logic [31:0]   reqWdata;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          wFire;
  logic          wWe;
  logic [AW+1:0] wAddr;
  logic [1:0]    wSize;
  logic [31:0]   wData;
  logic [3:0]    wBe;
  logic [31:0]   wLanes;
  logic          writeEn;

  logic [31:0] rdWord;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] rdExt;
  logic        respMis;

  logic unusedBits;
  assign unusedBits = ^i_addr[31:AW+2];

  function automatic logic misal(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic m;
    unique case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  assign accept  = (state == IDLE) && i_req;
  assign o_ready = (state == IDLE);

  // next-state and wait-counter control
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (i_req) begin
          stateNext = (LATENCY == 0) ? RESP : WAIT;
          cntNext   = LOADCNT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) stateNext = RESP;
        else cntNext = cnt - 3'd1;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // state register and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // capture the request at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqWe    <= 1'b0;
      reqAddr  <= '0;
      reqSize  <= 2'b00;
      reqUns   <= 1'b0;
      reqWdata <= 32'd0;
    end else if (accept) begin
      reqWe    <= i_we;
      reqAddr  <= i_addr[AW+1:0];
      reqSize  <= i_size;
      reqUns   <= i_unsigned;
      reqWdata <= i_wdata;
    end
  end

  // zero-latency builds write straight from the request inputs
  always_comb begin
    if (LATENCY == 0) begin
      wFire = accept;
      wWe   = i_we;
      wAddr = i_addr[AW+1:0];
      wSize = i_size;
      wData = i_wdata;
    end else begin
      wFire = (state == WAIT) && (cnt == 3'd0);
      wWe   = reqWe;
      wAddr = reqAddr;
      wSize = reqSize;
      wData = reqWdata;
    end
  end

  // lane enables and replicated store data
  always_comb begin
    wBe    = 4'b0000;
    wLanes = 32'd0;
    unique case (wSize)
      2'b00: begin
        wBe    = 4'b0001 << wAddr[1:0];
        wLanes = {4{wData[7:0]}};
      end
      2'b01: begin
        wBe    = wAddr[1] ? 4'b1100 : 4'b0011;
        wLanes = {2{wData[15:0]}};
      end
      default: begin
        wBe    = 4'b1111;
        wLanes = wData;
      end
    endcase
  end

  assign writeEn = rst && wFire && wWe &&
                   !misal(wSize, wAddr[1:0]);

  // lane-masked memory write, contents survive reset
  always_ff @(posedge clk) begin
    if (writeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (wBe[b]) begin
          mem[wAddr[AW+1:2]][8*b +: 8] <= wLanes[8*b +: 8];
        end
      end
    end
  end

  assign rdWord  = mem[reqAddr[AW+1:2]];
  assign rdByte  = rdWord[8*reqAddr[1:0] +: 8];
  assign rdHalf  = reqAddr[1] ? rdWord[31:16] : rdWord[15:0];
  assign respMis = misal(reqSize, reqAddr[1:0]);

  // lane select and extension of load data
  always_comb begin
    rdExt = rdWord;
    unique case (reqSize)
      2'b00: rdExt = reqUns ? {24'd0, rdByte}
                            : {{24{rdByte[7]}}, rdByte};
      2'b01: rdExt = reqUns ? {16'd0, rdHalf}
                            : {{16{rdHalf[15]}}, rdHalf};
      default: rdExt = rdWord;
    endcase
  end

  // response outputs are quiet outside RESP
  always_comb begin
    o_valid    = 1'b0;
    o_misalign = 1'b0;
    o_rdata    = 32'd0;
    if (state == RESP) begin
      o_valid    = 1'b1;
      o_misalign = respMis;
      if (!respMis && !reqWe) o_rdata = rdExt;
    end
  end

`ifdef LSU_DMEM_PERF_EN
  // saturating count of completed accesses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_access_cnt <= 32'd0;
    end else if (o_valid && (o_access_cnt != 32'hFFFF_FFFF)) begin
      o_access_cnt <= o_access_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed checks on a LATENCY=2 and a LATENCY=0 unit
// Counter checks are active when LSU_DMEM_PERF_EN is defined
module tb_lsu_dmem;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req1 = 1'b0;
  logic        req2 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] wdata = 32'd0;

  logic        ready1, valid1, mis1;
  logic [31:0] rdata1;
  logic        ready2, valid2, mis2;
  logic [31:0] rdata2;
`ifdef LSU_DMEM_PERF_EN
  logic [31:0] cnt1, cnt2;
`endif

  int nCmp = 0;
  int nBad = 0;

  lsu_dmem #(.DEPTH(64), .LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .i_req(req1), .i_we(we),
    .i_addr(addr), .i_size(size), .i_unsigned(uns),
    .i_wdata(wdata), .o_ready(ready1), .o_valid(valid1),
    .o_rdata(rdata1), .o_misalign(mis1)
`ifdef LSU_DMEM_PERF_EN
    , .o_access_cnt(cnt1)
`endif
  );

  lsu_dmem #(.DEPTH(64), .LATENCY(0)) dut2 (
    .clk(clk), .rst(rst), .i_req(req2), .i_we(we),
    .i_addr(addr), .i_size(size), .i_unsigned(uns),
    .i_wdata(wdata), .o_ready(ready2), .o_valid(valid2),
    .o_rdata(rdata2), .o_misalign(mis2)
`ifdef LSU_DMEM_PERF_EN
    , .o_access_cnt(cnt2)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doAcc(input bit which, input logic w,
                       input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       output logic [31:0] rd, output logic m,
                       output int lat);
    @(negedge clk);
    chk("ready_before_req", {31'd0, which ? ready2 : ready1}, 1);
    we = w; addr = a; size = sz; uns = u; wdata = wd;
    if (which) req2 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    req2 = 1'b0;
    lat = 0; rd = 32'd0; m = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (which ? valid2 : valid1) begin
        rd = which ? rdata2 : rdata1;
        m  = which ? mis2 : mis1;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        m;
  int          lat;
  logic        vSeen;
  logic [9:0]  pat;
  logic [31:0] cntBase;

  initial begin
    cntBase = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready1}, 1);
    chk("rst_valid", {31'd0, valid1}, 0);
    chk("rst_rdata", rdata1, 0);
    chk("rst_mis", {31'd0, mis1}, 0);
`ifdef LSU_DMEM_PERF_EN
    chk("rst_cnt", cnt1, 0);
`endif
    rst = 1'b1;

    doAcc(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, rd, m, lat);
    chk("sw_lat", lat, 3);
    chk("sw_mis", {31'd0, m}, 0);
    doAcc(0, 0, 32'h10, 2'b10, 0, 0, rd, m, lat);
    chk("lw_lat", lat, 3);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_mis", {31'd0, m}, 0);

    doAcc(0, 1, 32'h10, 2'b10, 0, 32'h0, rd, m, lat);
    doAcc(0, 1, 32'h11, 2'b00, 0, 32'hFFFFFF80, rd, m, lat);
    chk("sb_mis", {31'd0, m}, 0);
    doAcc(0, 0, 32'h11, 2'b00, 0, 0, rd, m, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    doAcc(0, 0, 32'h11, 2'b00, 1, 0, rd, m, lat);
    chk("lbu", rd, 32'h00000080);
    doAcc(0, 0, 32'h10, 2'b10, 0, 0, rd, m, lat);
    chk("lw_after_sb", rd, 32'h00008000);

    doAcc(0, 1, 32'h12, 2'b01, 0, 32'h1234BEEF, rd, m, lat);
    doAcc(0, 0, 32'h12, 2'b01, 0, 0, rd, m, lat);
    chk("lh_signed", rd, 32'hFFFFBEEF);
    doAcc(0, 0, 32'h12, 2'b01, 1, 0, rd, m, lat);
    chk("lhu", rd, 32'h0000BEEF);
    doAcc(0, 0, 32'h10, 2'b10, 1, 0, rd, m, lat);
    chk("lw_uns_ignored", rd, 32'hBEEF8000);

    doAcc(0, 1, 32'h13, 2'b01, 0, 32'h00005678, rd, m, lat);
    chk("sh_mis_flag", {31'd0, m}, 1);
    chk("sh_mis_rdata", rd, 0);
    chk("sh_mis_lat", lat, 3);
    doAcc(0, 0, 32'h10, 2'b10, 0, 0, rd, m, lat);
    chk("lw_after_missh", rd, 32'hBEEF8000);
    doAcc(0, 0, 32'h12, 2'b10, 0, 0, rd, m, lat);
    chk("lw_mis_flag", {31'd0, m}, 1);
    chk("lw_mis_rdata", rd, 0);
    doAcc(0, 0, 32'h13, 2'b00, 1, 0, rd, m, lat);
    chk("lbu_odd", rd, 32'h000000BE);
    chk("lbu_odd_mis", {31'd0, m}, 0);

    doAcc(0, 1, 32'h100, 2'b10, 0, 32'h12345678, rd, m, lat);
    doAcc(0, 0, 32'h000, 2'b10, 0, 0, rd, m, lat);
    chk("wrap", rd, 32'h12345678);

    doAcc(0, 1, 32'h20, 2'b10, 0, 32'h55555555, rd, m, lat);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; size = 2'b10; wdata = 32'hAAAAAAAA;
    req1 = 1'b1;
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    chk("wait_ready", {31'd0, ready1}, 0);
    chk("wait_valid", {31'd0, valid1}, 0);
    chk("wait_rdata", rdata1, 0);
    rst = 1'b0;
    #1;
    chk("rstw_ready", {31'd0, ready1}, 1);
    chk("rstw_valid", {31'd0, valid1}, 0);
    vSeen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vSeen = vSeen | valid1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vSeen = vSeen | valid1;
    end
    chk("rstw_no_valid", {31'd0, vSeen}, 0);
    doAcc(0, 0, 32'h20, 2'b10, 0, 0, rd, m, lat);
    chk("rstw_no_write", rd, 32'h55555555);

    doAcc(0, 1, 32'h44, 2'b10, 0, 32'h0, rd, m, lat);
    @(negedge clk);
    we = 1'b1; addr = 32'h40; size = 2'b10; wdata = 32'h77;
    req1 = 1'b1;
    @(posedge clk);
    #1 addr = 32'h44;
    wdata = 32'h99;
    vSeen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid1) begin
        vSeen = 1'b1;
        break;
      end
    end
    req1 = 1'b0;
    chk("busy_first_done", {31'd0, vSeen}, 1);
    vSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      vSeen = vSeen | valid1;
    end
    chk("busy_not_queued", {31'd0, vSeen}, 0);
    doAcc(0, 0, 32'h44, 2'b10, 0, 0, rd, m, lat);
    chk("busy_no_write", rd, 0);
    doAcc(0, 0, 32'h40, 2'b10, 0, 0, rd, m, lat);
    chk("busy_first_wr", rd, 32'h77);

    doAcc(1, 1, 32'h8, 2'b10, 0, 32'hCAFEF00D, rd, m, lat);
    chk("l0_sw_lat", lat, 1);
    doAcc(1, 0, 32'h8, 2'b10, 0, 0, rd, m, lat);
    chk("l0_lw_lat", lat, 1);
    chk("l0_lw_data", rd, 32'hCAFEF00D);
    doAcc(1, 1, 32'h9, 2'b00, 0, 32'h0000005A, rd, m, lat);
    doAcc(1, 0, 32'h8, 2'b10, 0, 0, rd, m, lat);
    chk("l0_sb_merge", rd, 32'hCAFE5A0D);

    @(negedge clk);
`ifdef LSU_DMEM_PERF_EN
    cntBase = cnt2;
`endif
    we = 1'b0; addr = 32'h8; size = 2'b10; uns = 1'b0;
    req2 = 1'b1;
    pat = 10'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = valid2;
      if (i == 9) req2 = 1'b0;
    end
    chk("l0_b2b_pattern", {22'd0, pat}, 32'h155);
    @(negedge clk);
    @(negedge clk);
`ifdef LSU_DMEM_PERF_EN
    chk("l0_cnt_delta", cnt2 - cntBase, 5);
`endif
    chk("l0_idle_after", {31'd0, valid2}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
